vga_timing_detector: RTL
========================

Name: vga_timing_detector

Overview:
Sink-side counterpart of the team's VGA timing generator. Accepts incoming hsync/vsync/data-enable on the pixel clock, recovers per-pixel x/y coordinates and measures the line and frame geometry. It also declares lock once the geometry is stable. It sits at the input of the image-processing pipeline and feeds coordinates and a lock flag to downstream filters and to the frame buffer writer.

Parameters:
LOCK_FRAMES, 3, number of consecutive identical frames required before locked asserts (1..15)
H_TIMEOUT, 4095, clocks without an hsync rising edge before signal-loss is declared
V_TIMEOUT, 2047, lines without a vsync rising edge before signal-loss is declared

Ports:
clk  input  1  pixel clock
rst_n  input  1  asynchronous active-low reset
hsync_in  input  1  horizontal sync, active high, synchronous to clk
vsync_in  input  1  vertical sync, active high, synchronous to clk
de_in  input  1  data enable, high during active pixels
x  output  12  recovered pixel column within the active line
y  output  11  recovered active line index within the frame
valid  output  1  de_in delayed to align with x/y
frame_start  output  1  one-cycle pulse on the first active pixel of each frame
h_total  output  12  measured clocks per line
h_active  output  12  measured de-high clocks per line
v_total  output  11  measured lines per frame
v_active  output  11  measured active lines per frame
locked  output  1  geometry stable for LOCK_FRAMES frames

Behaviour:
- Reset (async, rst_n=0): every output is 0, every internal counter is 0, and the stable-frame count is 0. A reset mid-frame discards any partial measurement. Measurement restarts at the next hsync/vsync rising edge.
- Input stage: hsync_in, vsync_in and de_in are registered once. Edges are detected by comparing the registered value against a second registered copy. A rising edge on the input at cycle t is visible internally at t+2.
- Coordinates: total latency is 2 cycles, so valid at t+2 equals de_in at t.
  - x is 0 on the first de-high cycle of a line and increments by 1 each subsequent de-high cycle.
  - x holds its last value while de is low.
  - y is cleared to 0 on each vsync rising edge and increments by 1 on each de falling edge.
  - The first active line therefore has y=0.
- frame_start is high together with valid on the first de-high cycle after a vsync rising edge. It is high for exactly 1 cycle.
- h_total = clocks from one hsync rising edge (inclusive) to the next (exclusive). It is updated on each hsync rising edge, except the first one after reset or after signal loss.
- h_active = de-high clocks in the most recently completed active line. It is updated on each de falling edge.
- v_total = hsync rising edges counted from one vsync rising edge (inclusive) to the next (exclusive). It is updated on each vsync rising edge, except the first one.
- v_active = de falling edges between consecutive vsync rising edges. It is updated on each vsync rising edge, except the first one.
- Counters saturate at their maximum value (4095 / 2047) and never wrap.
- Simultaneous events: hsync and vsync rising in the same cycle are both processed. The line counter for the new frame starts at 1, counting the hsync edge that coincides with the vsync edge.
- Lock FSM states: SEARCH, CHECK, LOCKED.
  - SEARCH → CHECK on the first complete frame measurement.
  - At each vsync rising edge in CHECK, the snapshot {h_total, h_active, v_total, v_active} is compared with the previous frame's snapshot.
  - Equal: stable count +1.
  - Different: stable count cleared to 0 and the FSM stays in CHECK.
  - CHECK → LOCKED when the stable count reaches LOCK_FRAMES. locked=1 is registered, one cycle after that vsync edge is detected.
  - LOCKED → CHECK on any snapshot mismatch. locked drops the cycle after detection and the stable count is cleared.
- Signal loss: from any state the FSM goes to SEARCH if more than H_TIMEOUT clocks pass without an hsync rising edge, or more than V_TIMEOUT lines pass without a vsync rising edge. On signal loss:
  - locked=0;
  - h_total, h_active, v_total, v_active are cleared to 0;
  - x and y hold their values.
- A glitch of 1-cycle hsync produces a short h_total measurement. This must cause a lock mismatch; it is not filtered.

Test Plan:
- Generator with H 16/2/3/4 (total 25) and V 8/1/2/3 (total 14), LOCK_FRAMES=3, from reset → h_total=25, h_active=16, v_total=14, v_active=8 after frame 2; locked rises 1 cycle after the 4th vsync rising edge.
- Same stream → valid rises exactly 2 cycles after de_in; x runs 0..15 on each line; y runs 0..7; frame_start pulses once per frame, together with x=0 and y=0.
- Locked stream, then line length changed to 26 clocks for one frame → locked falls 1 cycle after the next vsync edge is detected; it re-asserts after 3 further identical frames.
- hsync_in held low for 4100 clocks while locked → locked=0 and all measurements equal 0 by clock 4096; the FSM is in SEARCH.
- rst_n pulsed low mid-line while locked → all outputs are 0 immediately (asynchronously); re-lock follows the first-frame sequence of scenario 1.
- hsync and vsync rising in the same cycle → v_total=14 (not 13 or 15) and the y sequence is unchanged.

Source files
------------

// File: rtl/vga_timing_detector.sv
// Sink-side VGA timing recovery: registers the sync/DE inputs, recovers pixel coordinates,
// measures line/frame geometry and declares lock once that geometry repeats.
module vga_timing_detector #(
  parameter int unsigned LOCK_FRAMES = 3,
  parameter int unsigned H_TIMEOUT   = 4095,
  parameter int unsigned V_TIMEOUT   = 2047
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        de_in,
  output logic [11:0] x,
  output logic [10:0] y,
  output logic        valid,
  output logic        frame_start,
  output logic [11:0] h_total,
  output logic [11:0] h_active,
  output logic [10:0] v_total,
  output logic [10:0] v_active,
  output logic        locked
);

  typedef enum logic [1:0] {StSearch, StCheck, StLocked} lock_state_e;

  logic        hs_q1, hs_q2, vs_q1, vs_q2, de_q1, de_q2;
  logic        hs_rise, vs_rise, de_rise, de_fall;
  logic [11:0] h_cnt_q, de_cnt_q;
  logic [10:0] v_cnt_q, va_cnt_q;
  logic        h_seen_q, v_seen_q, de_ok_q, fs_pend_q;
  logic        h_loss, v_loss, sig_loss;
  logic [45:0] snap, prev_snap_q;
  logic        snap_match;
  logic [3:0]  stable_q;
  logic [4:0]  stable_inc;
  lock_state_e state_q;

  assign hs_rise = hs_q1 & ~hs_q2;
  assign vs_rise = vs_q1 & ~vs_q2;
  assign de_rise = de_q1 & ~de_q2;
  assign de_fall = ~de_q1 & de_q2;

  // h_cnt_q doubles as the idle timer; v_cnt_q counts lines since the last vsync edge.
  assign h_loss   = ({20'd0, h_cnt_q} >= H_TIMEOUT) & ~hs_rise;
  assign v_loss   = ({21'd0, v_cnt_q} >= V_TIMEOUT) & ~vs_rise;
  assign sig_loss = h_loss | v_loss;

  // The frame just closed by vs_rise is still held in the running line/DE-fall counters.
  assign snap       = {h_total, h_active, v_cnt_q, va_cnt_q};
  assign snap_match = (snap == prev_snap_q);
  assign stable_inc = {1'b0, stable_q} + 5'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q1       <= 1'b0;
      hs_q2       <= 1'b0;
      vs_q1       <= 1'b0;
      vs_q2       <= 1'b0;
      de_q1       <= 1'b0;
      de_q2       <= 1'b0;
      h_cnt_q     <= '0;
      de_cnt_q    <= '0;
      v_cnt_q     <= '0;
      va_cnt_q    <= '0;
      h_seen_q    <= 1'b0;
      v_seen_q    <= 1'b0;
      de_ok_q     <= 1'b0;
      fs_pend_q   <= 1'b0;
      x           <= '0;
      y           <= '0;
      valid       <= 1'b0;
      frame_start <= 1'b0;
      h_total     <= '0;
      h_active    <= '0;
      v_total     <= '0;
      v_active    <= '0;
    end else begin
      hs_q1 <= hsync_in;
      hs_q2 <= hs_q1;
      vs_q1 <= vsync_in;
      vs_q2 <= vs_q1;
      de_q1 <= de_in;
      de_q2 <= de_q1;

      if (hs_rise) begin
        h_cnt_q  <= 12'd1;
        h_seen_q <= 1'b1;
        if (h_seen_q) h_total <= h_cnt_q;
      end else if (h_cnt_q != 12'hfff) begin
        h_cnt_q <= h_cnt_q + 12'd1;
      end

      if (de_rise) begin
        de_cnt_q <= 12'd1;
        de_ok_q  <= 1'b1;
      end else if (de_q1 && de_cnt_q != 12'hfff) begin
        de_cnt_q <= de_cnt_q + 12'd1;
      end
      if (de_fall && de_ok_q) h_active <= de_cnt_q;

      // An hsync edge coinciding with vsync is the first line of the new frame.
      if (vs_rise) begin
        v_seen_q <= 1'b1;
        if (v_seen_q) begin
          v_total  <= v_cnt_q;
          v_active <= va_cnt_q;
        end
        v_cnt_q  <= {10'd0, hs_rise};
        va_cnt_q <= {10'd0, de_fall};
      end else begin
        if (hs_rise && v_cnt_q != 11'h7ff) v_cnt_q <= v_cnt_q + 11'd1;
        if (de_fall && va_cnt_q != 11'h7ff) va_cnt_q <= va_cnt_q + 11'd1;
      end

      valid <= de_q1;
      if (de_rise) x <= '0;
      else if (de_q1 && x != 12'hfff) x <= x + 12'd1;
      if (vs_rise) y <= '0;
      else if (de_fall && y != 11'h7ff) y <= y + 11'd1;

      frame_start <= de_rise & (fs_pend_q | vs_rise);
      if (de_rise) fs_pend_q <= 1'b0;
      else if (vs_rise) fs_pend_q <= 1'b1;

      // Loss discards all geometry; coordinates are left as they were.
      if (sig_loss) begin
        h_total  <= '0;
        h_active <= '0;
        v_total  <= '0;
        v_active <= '0;
        h_seen_q <= 1'b0;
        v_seen_q <= 1'b0;
        de_ok_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StSearch;
      stable_q    <= '0;
      locked      <= 1'b0;
      prev_snap_q <= '0;
    end else if (sig_loss) begin
      state_q  <= StSearch;
      stable_q <= '0;
      locked   <= 1'b0;
    end else if (vs_rise && v_seen_q) begin
      prev_snap_q <= snap;
      case (state_q)
        StSearch: begin
          stable_q <= 4'd1;
          if (LOCK_FRAMES <= 1) begin
            state_q <= StLocked;
            locked  <= 1'b1;
          end else begin
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (snap_match) begin
            stable_q <= stable_inc[3:0];
            if ({27'd0, stable_inc} >= LOCK_FRAMES) begin
              state_q <= StLocked;
              locked  <= 1'b1;
            end
          end else begin
            stable_q <= '0;
          end
        end
        StLocked: begin
          if (!snap_match) begin
            state_q  <= StCheck;
            stable_q <= '0;
            locked   <= 1'b0;
          end
        end
        default: begin
          state_q  <= StSearch;
          stable_q <= '0;
          locked   <= 1'b0;
        end
      endcase
    end
  end

endmodule
